// File: rtl/booth_pkg.sv
// Shared Booth multiplier definitions: command encodings consumed by the
// control FSM and by the datapath ALU mux, plus the control state enum.
package booth_pkg;

  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_OP,
    ST_SHIFT,
    ST_DONE
  } booth_state_e;

endpackage

// File: rtl/booth_decode.sv
// Radix-2 Booth bit-pair decoder: {Q[-1], Q[0]} -> add/sub/no-op command.
module booth_decode
  import booth_pkg::*;
(
  input  logic       i_q0,
  input  logic       i_q1,
  output logic [1:0] o_booth_op
);

  always_comb begin
    o_booth_op = BOOTH_NOP;
    case ({i_q1, i_q0})
      2'b01:   o_booth_op = BOOTH_SUB;
      2'b10:   o_booth_op = BOOTH_ADD;
      default: o_booth_op = BOOTH_NOP;
    endcase
  end

endmodule

// File: rtl/booth_control_unit.sv
// Booth multiplier sequencer: LOAD, then WIDTH OP/SHIFT pairs, then a DONE pulse.
module booth_control_unit
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          q0,
  input  logic          q1,
  output logic [1:0]    BoothOp,
  output logic          load_en,
  output logic          acc_en,
  output logic          shift_en,
  output logic [CW-1:0] count,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] LP_WIDTH = CW'(WIDTH);

  booth_state_e  r_state;
  booth_state_e  w_state_nxt;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_count_inc;
  logic [1:0]    w_booth_op;

  booth_decode u_decode (
    .i_q0       (q0),
    .i_q1       (q1),
    .o_booth_op (w_booth_op)
  );

  assign BoothOp     = w_booth_op;
  assign count       = r_count;
  assign w_count_inc = r_count + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // acc_en in OP is combinational from q0/q1 so the datapath's current bits act this cycle
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    load_en     = 1'b0;
    acc_en      = 1'b0;
    shift_en    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        load_en     = 1'b1;
        busy        = 1'b1;
        w_count_nxt = '0;
        w_state_nxt = ST_OP;
      end
      ST_OP: begin
        busy        = 1'b1;
        acc_en      = (w_booth_op != BOOTH_NOP);
        w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        if (r_count != LP_WIDTH) w_count_nxt = w_count_inc;
        w_state_nxt = (w_count_inc == LP_WIDTH) ? ST_DONE : ST_OP;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_booth_control_unit.sv
// Directed bench for booth_control_unit: WIDTH=32 and WIDTH=4 instances, each
// driving a small external A/Q/Q[-1]/M datapath model from the DUT enables.
module tb_booth_control_unit;

  logic clk = 1'b0;
  bit   clk_run = 1'b0;
  logic rst = 1'b0;
  logic start32 = 1'b0;
  logic start4 = 1'b0;
  logic q0_drv = 1'b0;
  logic q1_drv = 1'b0;
  logic use_model = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  // WIDTH=32 instance and its datapath
  logic [1:0]  op32;
  logic        ld32, acc32, sh32, busy32, done32;
  logic [5:0]  cnt32;
  logic        q0_32, q1_32;
  logic [31:0] A32, Q32, M32, mult32, mcand32;
  logic        qm32;

  assign q0_32 = use_model ? Q32[0] : q0_drv;
  assign q1_32 = use_model ? qm32   : q1_drv;

  booth_control_unit #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .start(start32), .q0(q0_32), .q1(q1_32),
    .BoothOp(op32), .load_en(ld32), .acc_en(acc32), .shift_en(sh32),
    .count(cnt32), .busy(busy32), .done(done32)
  );

  always @(posedge clk) begin
    if (ld32) begin
      A32 <= '0; Q32 <= mult32; M32 <= mcand32; qm32 <= 1'b0;
    end else if (acc32) begin
      A32 <= (op32 == 2'b10) ? A32 - M32 : A32 + M32;
    end else if (sh32) begin
      {A32, Q32, qm32} <= {A32[31], A32, Q32};
    end
  end

  // WIDTH=4 instance and its datapath
  logic [1:0] op4;
  logic       ld4, acc4, sh4, busy4, done4;
  logic [2:0] cnt4;
  logic       q0_4, q1_4;
  logic [3:0] A4, Q4, M4, mult4, mcand4;
  logic       qm4;

  assign q0_4 = use_model ? Q4[0] : q0_drv;
  assign q1_4 = use_model ? qm4   : q1_drv;

  booth_control_unit #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .q0(q0_4), .q1(q1_4),
    .BoothOp(op4), .load_en(ld4), .acc_en(acc4), .shift_en(sh4),
    .count(cnt4), .busy(busy4), .done(done4)
  );

  always @(posedge clk) begin
    if (ld4) begin
      A4 <= '0; Q4 <= mult4; M4 <= mcand4; qm4 <= 1'b0;
    end else if (acc4) begin
      A4 <= (op4 == 2'b10) ? A4 - M4 : A4 + M4;
    end else if (sh4) begin
      {A4, Q4, qm4} <= {A4[3], A4, Q4};
    end
  end

  task automatic test_decode();
    logic [1:0] exp_tab [4];
    exp_tab = '{2'b00, 2'b10, 2'b01, 2'b00};
    use_model = 1'b0;
    for (int i = 0; i < 4; i++) begin
      q1_drv = i[1];
      q0_drv = i[0];
      #100;
      n_cmp++;
      if (op32 !== exp_tab[i]) begin
        n_err++;
        $display("FAIL decode32[%0d]: got %b expected %b", i, op32, exp_tab[i]);
      end
      n_cmp++;
      if (op4 !== exp_tab[i]) begin
        n_err++;
        $display("FAIL decode4[%0d]: got %b expected %b", i, op4, exp_tab[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy32, done32, ld32, acc32, sh32} !== 5'b0 || cnt32 !== 6'd0) begin
      n_err++;
      $display("FAIL reset32: got busy/done/ld/acc/sh=%b count=%0d expected 00000 count=0",
               {busy32, done32, ld32, acc32, sh32}, cnt32);
    end
    n_cmp++;
    if ({busy4, done4, ld4, acc4, sh4} !== 5'b0 || cnt4 !== 3'd0) begin
      n_err++;
      $display("FAIL reset4: got busy/done/ld/acc/sh=%b count=%0d expected 00000 count=0",
               {busy4, done4, ld4, acc4, sh4}, cnt4);
    end
    clk_run = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy32 !== 1'b0 || done32 !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy32, done32);
    end
  endtask

  // One WIDTH=32 multiplication of 0xFFFFFFFD by 7; start is re-driven high
  // during cycles glitch_lo..glitch_hi (counted from LOAD=1) and must be ignored.
  task automatic run32(input int glitch_lo, input int glitch_hi);
    int cyc, n_op, n_sh, n_acc, excl_bad, acc_bad;
    bit got_done;
    mult32 = 32'hFFFF_FFFD;
    mcand32 = 32'd7;
    use_model = 1'b1;
    @(negedge clk) start32 = 1'b1;
    @(negedge clk) start32 = 1'b0;
    cyc = 1; n_op = 0; n_sh = 0; n_acc = 0; excl_bad = 0; acc_bad = 0; got_done = 1'b0;
    n_cmp++;
    if (ld32 !== 1'b1 || busy32 !== 1'b1) begin
      n_err++;
      $display("FAIL load32: got load_en=%b busy=%b expected 1 1", ld32, busy32);
    end
    while (!got_done && cyc < 200) begin
      if (int'(ld32) + int'(acc32) + int'(sh32) > 1) excl_bad++;
      if (busy32 && !ld32 && !sh32) begin
        n_op++;
        if (acc32 !== (q0_32 != q1_32)) acc_bad++;
      end
      if (acc32) n_acc++;
      if (sh32) n_sh++;
      start32 = (cyc >= glitch_lo && cyc <= glitch_hi);
      if (done32 === 1'b1) got_done = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    start32 = 1'b0;
    n_cmp++;
    if (!got_done || cyc != 66) begin
      n_err++;
      $display("FAIL done_cycle32: got done=%b at cycle %0d expected done at cycle 66", got_done, cyc);
    end
    n_cmp++;
    if (n_op != 32 || n_sh != 32 || n_acc != 3) begin
      n_err++;
      $display("FAIL iter32: got op=%0d shift=%0d acc=%0d expected 32 32 3", n_op, n_sh, n_acc);
    end
    n_cmp++;
    if (excl_bad != 0 || acc_bad != 0) begin
      n_err++;
      $display("FAIL exclusive32: got excl_bad=%0d acc_bad=%0d expected 0 0", excl_bad, acc_bad);
    end
    n_cmp++;
    if ({A32, Q32} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      n_err++;
      $display("FAIL product32: got %h expected ffffffffffffffeb", {A32, Q32});
    end
    n_cmp++;
    if (cnt32 !== 6'd32 || busy32 !== 1'b0) begin
      n_err++;
      $display("FAIL done_state32: got count=%0d busy=%b expected 32 0", cnt32, busy32);
    end
    @(negedge clk);
    n_cmp++;
    if (busy32 !== 1'b0 || done32 !== 1'b0 || cnt32 !== 6'd32) begin
      n_err++;
      $display("FAIL idle_hold32: got busy=%b done=%b count=%0d expected 0 0 32", busy32, done32, cnt32);
    end
  endtask

  task automatic test_full_run();
    run32(0, 0);
  endtask

  task automatic test_start_while_busy();
    run32(10, 30);
  endtask

  task automatic test_start_held();
    int cyc;
    use_model = 1'b1;
    @(negedge clk) start32 = 1'b1;
    @(negedge clk);
    cyc = 1;
    while (done32 !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (cyc != 66) begin
      n_err++;
      $display("FAIL held_done: got done at cycle %0d expected 66", cyc);
    end
    @(negedge clk);
    n_cmp++;
    if (busy32 !== 1'b0 || ld32 !== 1'b0) begin
      n_err++;
      $display("FAIL held_idle: got busy=%b load_en=%b expected 0 0", busy32, ld32);
    end
    @(negedge clk);
    start32 = 1'b0;
    n_cmp++;
    if (ld32 !== 1'b1) begin
      n_err++;
      $display("FAIL held_restart: got load_en=%b expected 1", ld32);
    end
  endtask

  // Entered while the restarted run from test_start_held is in progress.
  task automatic test_reset_midrun();
    int late_done;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy32, done32, ld32, acc32, sh32} !== 5'b0 || cnt32 !== 6'd0) begin
      n_err++;
      $display("FAIL reset_mid: got busy/done/ld/acc/sh=%b count=%0d expected 00000 count=0",
               {busy32, done32, ld32, acc32, sh32}, cnt32);
    end
    use_model = 1'b0;
    q1_drv = 1'b0;
    q0_drv = 1'b1;
    #1;
    n_cmp++;
    if (op32 !== 2'b10) begin
      n_err++;
      $display("FAIL reset_boothop_sub: got %b expected 10", op32);
    end
    q1_drv = 1'b1;
    q0_drv = 1'b0;
    #1;
    n_cmp++;
    if (op32 !== 2'b01) begin
      n_err++;
      $display("FAIL reset_boothop_add: got %b expected 01", op32);
    end
    @(negedge clk) rst = 1'b0;
    late_done = 0;
    repeat (80) begin
      @(negedge clk);
      if (done32 !== 1'b0 || busy32 !== 1'b0) late_done++;
    end
    n_cmp++;
    if (late_done != 0) begin
      n_err++;
      $display("FAIL reset_no_done: got %0d active cycles expected 0", late_done);
    end
  endtask

  task automatic test_width4();
    logic [1:0] ops [4];
    logic [1:0] exp_ops [4];
    int cyc, n_op;
    exp_ops = '{2'b10, 2'b01, 2'b10, 2'b01};
    ops = '{2'b11, 2'b11, 2'b11, 2'b11};
    mult4 = 4'b0101;
    mcand4 = 4'd3;
    use_model = 1'b1;
    @(negedge clk) start4 = 1'b1;
    @(negedge clk) start4 = 1'b0;
    cyc = 1;
    n_op = 0;
    while (done4 !== 1'b1 && cyc < 40) begin
      if (busy4 && !ld4 && !sh4) begin
        if (n_op < 4) ops[n_op] = op4;
        n_op++;
      end
      @(negedge clk);
      cyc++;
    end
    n_cmp++;
    if (cyc != 10) begin
      n_err++;
      $display("FAIL done_cycle4: got done at cycle %0d expected 10", cyc);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (ops[i] !== exp_ops[i]) begin
        n_err++;
        $display("FAIL op_pattern4[%0d]: got %b expected %b", i, ops[i], exp_ops[i]);
      end
    end
    n_cmp++;
    if (n_op != 4 || cnt4 !== 3'd4) begin
      n_err++;
      $display("FAIL iter4: got op=%0d count=%0d expected 4 4", n_op, cnt4);
    end
    n_cmp++;
    if ({A4, Q4} !== 8'h0F) begin
      n_err++;
      $display("FAIL product4: got %h expected 0f", {A4, Q4});
    end
  endtask

  initial begin
    A32 = '0; Q32 = '0; M32 = '0; qm32 = 1'b0; mult32 = '0; mcand32 = '0;
    A4 = '0; Q4 = '0; M4 = '0; qm4 = 1'b0; mult4 = '0; mcand4 = '0;
    test_decode();
    test_reset();
    test_full_run();
    test_start_while_busy();
    test_start_held();
    test_reset_midrun();
    test_width4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
